// File: rtl/pix_stream_pkg.sv
// rtl/pix_stream_pkg.sv - shared types, constants and helpers for the pixel stream blocks
package pix_stream_pkg;

    localparam int PIX_W       = 8;
    localparam int N_DEFAULT   = 480;
    localparam int M_DEFAULT   = 320;
    localparam int GAP_DEFAULT = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STREAM,
        S_GAP
    } pix_state_e;

    // Number of bits needed to index v distinct values (0 for v <= 1).
    function automatic int clog2(input int unsigned v);
        int          r;
        int unsigned p;
        r = 0;
        p = 1;
        for (int i = 0; i < 32; i++) begin
            if (p < v) begin
                r = i + 1;
                p = p << 1;
            end
        end
        return r;
    endfunction

    // Counter width that is never zero, so a 1-row or 1-column image still gets a real signal.
    function automatic int cnt_w(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pix_tx_raster_cnt.sv
// rtl/pix_tx_raster_cnt.sv - raster-order linear address with row/column counters
module pix_tx_raster_cnt
    import pix_stream_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int M      = M_DEFAULT,
    parameter int ADDR_W = 18,
    parameter int ROW_W  = cnt_w(N),
    parameter int COL_W  = cnt_w(M)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic              last_col,
    output logic              last_pix
);

    assign last_col = (col == COL_W'(M - 1));
    assign last_pix = last_col && (row == ROW_W'(N - 1));

    // Step one pixel per adv; wrap to the origin after the last pixel so the next frame starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            row  <= '0;
            col  <= '0;
        end else if (adv) begin
            if (last_pix) begin
                addr <= '0;
                row  <= '0;
                col  <= '0;
            end else begin
                addr <= addr + 1'b1;
                if (last_col) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pixel_frame_tx.sv
// rtl/pixel_frame_tx.sv - frame memory to pixel stream sender (option: PIXEL_FRAME_TX_TESTPAT_EN)
module pixel_frame_tx
    import pix_stream_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int M      = M_DEFAULT,
    parameter int GAP    = GAP_DEFAULT,
    parameter int ADDR_W = 18
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              dn_busy,
`ifdef PIXEL_FRAME_TX_TESTPAT_EN
    input  logic              pat_sel,
`endif
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_cnt
);

    localparam int ROW_W = cnt_w(N);
    localparam int COL_W = cnt_w(M);

    if (clog2(N * M) > ADDR_W) begin : g_addr_w_check
        $error("pixel_frame_tx: ADDR_W too small for N*M");
    end

    pix_state_e         state;
    pix_state_e         state_nxt;
    logic [7:0]         gap_cnt;
    logic               stream;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic               last_col;
    logic               last_pix;

    assign stream = (state == S_STREAM);
    assign busy   = (state != S_IDLE);

    pix_tx_raster_cnt #(
        .N      (N),
        .M      (M),
        .ADDR_W (ADDR_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W)
    ) u_raster (
        .clk      (clk),
        .rst      (rst),
        .adv      (stream),
        .addr     (mem_addr),
        .row      (row),
        .col      (col),
        .last_col (last_col),
        .last_pix (last_pix)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state. GAP lasts GAP+1 cycles: the first one drains the last pixel, the rest are idle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start)    state_nxt = S_WAIT;
            S_WAIT:   if (!dn_busy) state_nxt = S_STREAM;
            S_STREAM: if (last_pix) state_nxt = S_GAP;
            S_GAP:    if (gap_cnt == 8'(GAP)) state_nxt = cont ? S_WAIT : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Inter-frame gap counter, held at zero outside GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 gap_cnt <= '0;
        else if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
        else                     gap_cnt <= '0;
    end

    // Output stage: qualifier and markers follow the read cycle by one clock; done/frame_cnt one after eof.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            pix_valid <= stream;
            sof       <= stream && (row == '0) && (col == '0);
            eol       <= stream && last_col;
            eof       <= stream && last_pix;
            done      <= pix_valid && eof;
            if (pix_valid && eof) frame_cnt <= frame_cnt + 1'b1;
        end
    end

`ifdef PIXEL_FRAME_TX_TESTPAT_EN
    logic             pat_q;
    logic [PIX_W-1:0] pat_data;

    // Pattern select is latched on STREAM entry and held for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               pat_q <= 1'b0;
        else if ((state == S_WAIT) && !dn_busy) pat_q <= pat_sel;
    end

    // Pattern byte registered alongside the qualifier so both modes share the same latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pat_data <= '0;
        else     pat_data <= PIX_W'(row) + PIX_W'(col);
    end

    assign mem_en   = stream && !pat_q;
    assign pix_data = !pix_valid ? '0 : (pat_q ? pat_data : mem_rdata);
`else
    assign mem_en   = stream;
    // RAM data arrives the cycle after mem_en, which is the cycle pix_valid is high.
    assign pix_data = pix_valid ? mem_rdata : '0;
`endif

endmodule

// File: tb/tb_pixel_frame_tx.sv
// tb/tb_pixel_frame_tx.sv - scoreboard bench for pixel_frame_tx
module tb_pixel_frame_tx;

    localparam int N      = 4;
    localparam int M      = 3;
    localparam int GAP    = 2;
    localparam int ADDR_W = 18;
    localparam int NM     = N * M;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              cont = 1'b0;
    logic              dn_busy = 1'b0;
`ifdef PIXEL_FRAME_TX_TESTPAT_EN
    logic              pat_sel = 1'b0;
`endif
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        pix_data;
    logic              pix_valid, sof, eol, eof, busy, done;
    logic [15:0]       frame_cnt;

    logic [7:0]  mem [0:15];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [10:0] exp_q[$];
    int          bstart[$];
    int          blen[$];
    int          eof_cyc = -1;
    int          pix_seen = 0;
    int          memen_cnt = 0;
    int          cur_len = 0;
    logic        prev_v = 1'b0;

    pixel_frame_tx #(
        .N      (N),
        .M      (M),
        .GAP    (GAP),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cont      (cont),
        .dn_busy   (dn_busy),
`ifdef PIXEL_FRAME_TX_TESTPAT_EN
        .pat_sel   (pat_sel),
`endif
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .sof       (sof),
        .eol       (eol),
        .eof       (eof),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr[3:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_v  = 1'b0;
            cur_len = 0;
        end else begin
            if (mem_en) memen_cnt++;
            if (pix_valid) begin
                if (!prev_v) bstart.push_back(cyc);
                cur_len++;
                pix_seen++;
                if (eof) eof_cyc = cyc;
                chk("pix_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("pix_data_markers", {pix_data, sof, eol, eof}, exp_q.pop_front());
            end else if (prev_v) begin
                blen.push_back(cur_len);
                cur_len = 0;
            end
            prev_v = pix_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input bit pat);
        for (int a = 0; a < NM; a++) begin
            logic [7:0] d;
            d = pat ? 8'(a / M + a % M) : 8'(a + 16);
            exp_q.push_back({d, (a == 0), ((a % M) == M - 1), (a == NM - 1)});
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clear_bursts();
        bstart.delete();
        blen.delete();
    endtask

    task automatic wait_done(output int t);
        bit found;
        found = 1'b0;
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                t = cyc;
                found = 1'b1;
                break;
            end
        end
        chk("done_seen", found, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pix_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        chk("valid_seen", found, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, td, fc, base, mbase;
        for (int a = 0; a < 16; a++) mem[a] = 8'(a + 16);
        fc = 0;

        // reset state
        @(negedge clk);
        chk("rst_ctrl", {mem_en, pix_valid, sof, eol, eof, busy, done}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_pix", pix_data, 0);
        chk("rst_fcnt", frame_cnt, 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // single shot
        clear_bursts();
        push_frame(1'b0);
        t0 = cyc;
        pulse_start();
        wait_done(td);
        fc++;
        chk("t1_first_pix", (bstart.size() > 0) ? bstart[0] : -1, t0 + 3);
        chk("t1_len", (blen.size() > 0) ? blen[0] : -1, NM);
        chk("t1_done_lat", td, eof_cyc + 1);
        chk("t1_done_pulse", done, 0);
        chk("t1_busy_gap", busy, 1);
        chk("t1_q_empty", exp_q.size(), 0);
        chk("t1_fcnt", frame_cnt, fc);
        tick(3);
        chk("t1_busy_idle", busy, 0);

        // backpressure at start
        clear_bursts();
        dn_busy = 1'b1;
        push_frame(1'b0);
        mbase = memen_cnt;
        base = pix_seen;
        pulse_start();
        tick(10);
        chk("t2_no_mem_en", memen_cnt - mbase, 0);
        chk("t2_no_pix", pix_seen - base, 0);
        chk("t2_busy", busy, 1);
        dn_busy = 1'b0;
        t0 = cyc;
        wait_done(td);
        fc++;
        chk("t2_first_pix", (bstart.size() > 0) ? bstart[0] : -1, t0 + 2);
        chk("t2_q_empty", exp_q.size(), 0);
        chk("t2_fcnt", frame_cnt, fc);
        tick(5);

        // continuous mode, cont dropped during the third frame
        clear_bursts();
        cont = 1'b1;
        push_frame(1'b0);
        push_frame(1'b0);
        push_frame(1'b0);
        pulse_start();
        wait_done(td);
        wait_done(td);
        wait_valid();
        cont = 1'b0;
        wait_done(td);
        fc += 3;
        tick(10);
        chk("t3_bursts", bstart.size(), 3);
        if (bstart.size() == 3 && blen.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("t3_len", blen[i], NM);
            for (int i = 1; i < 3; i++) chk("t3_gap", bstart[i] - bstart[i-1] - NM, GAP + 2);
        end
        chk("t3_busy_idle", busy, 0);
        chk("t3_q_empty", exp_q.size(), 0);
        chk("t3_fcnt", frame_cnt, fc);

        // reset in the middle of a frame
        clear_bursts();
        push_frame(1'b0);
        base = pix_seen;
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            if (pix_seen - base >= 5) break;
            tick(1);
        end
        chk("t4_pix_before_rst", pix_seen - base, 5);
        rst = 1'b1;
        #1;
        chk("t4_rst_ctrl", {mem_en, pix_valid, sof, eol, eof, busy, done}, 0);
        chk("t4_rst_addr", mem_addr, 0);
        chk("t4_rst_pix", pix_data, 0);
        chk("t4_rst_fcnt", frame_cnt, 0);
        fc = 0;
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(1);
        clear_bursts();
        push_frame(1'b0);
        pulse_start();
        wait_done(td);
        fc++;
        chk("t4_bursts", bstart.size(), 1);
        chk("t4_len", (blen.size() > 0) ? blen[0] : -1, NM);
        chk("t4_q_empty", exp_q.size(), 0);
        chk("t4_fcnt", frame_cnt, fc);
        tick(5);

        // start pulses during STREAM and GAP are ignored
        clear_bursts();
        push_frame(1'b0);
        pulse_start();
        wait_valid();
        pulse_start();
        wait_done(td);
        pulse_start();
        tick(20);
        fc++;
        chk("t5_bursts", bstart.size(), 1);
        chk("t5_busy_idle", busy, 0);
        chk("t5_q_empty", exp_q.size(), 0);
        chk("t5_fcnt", frame_cnt, fc);

`ifdef PIXEL_FRAME_TX_TESTPAT_EN
        // test pattern mode
        clear_bursts();
        pat_sel = 1'b1;
        push_frame(1'b1);
        mbase = memen_cnt;
        pulse_start();
        wait_done(td);
        fc++;
        pat_sel = 1'b0;
        chk("t6_no_mem_en", memen_cnt - mbase, 0);
        chk("t6_len", (blen.size() > 0) ? blen[0] : -1, NM);
        chk("t6_q_empty", exp_q.size(), 0);
        chk("t6_fcnt", frame_cnt, fc);
        tick(5);
`endif

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_frame_tx.md
# pixel_frame_tx

- Streams one image frame from a frame memory into the pixel-stream input of the team's 5x5 Gaussian filter.
- Reads N*M bytes in raster order from a synchronous RAM and emits them as a contiguous pixel stream (pix_data, pix_valid), with frame/line markers.
- Holds off each frame until the filter reports it is idle.
- Supports single-shot and continuous (back-to-back frame) modes.

## Interface
- N, 480, image rows
- M, 320, image columns (pixels per row)
- GAP, 16, minimum idle cycles between frames (legal range 1..255)
- ADDR_W, 18, memory address width (must satisfy 2^ADDR_W >= N*M)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  frame request; sampled in IDLE only
- cont  in  1  continuous mode; sampled at end of GAP
- dn_busy  in  1  downstream busy (filter convolving); a frame may not start while high
- mem_en  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM read address, raster index row*M+col
- mem_rdata  in  8  RAM read data, valid exactly 1 cycle after mem_en
- pix_data  out  8  pixel byte to filter
- pix_valid  out  1  pixel qualifier
- sof  out  1  high with the first pixel of a frame
- eol  out  1  high with the last pixel of each row
- eof  out  1  high with the last pixel of a frame
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after each frame's last pixel
- frame_cnt  out  16  completed frames, wraps at 65535 -> 0

## Operation
- FSM states: IDLE, WAIT, STREAM, GAP.
- IDLE -> WAIT on start.
- WAIT -> STREAM on the first cycle dn_busy is sampled low. WAIT also absorbs the case where dn_busy is already low.
- STREAM:
  - Asserts mem_en every cycle with a linear address counter 0..N*M-1.
  - Tracks row (0..N-1) and column (0..M-1) counters alongside the address.
  - Goes to GAP in the cycle after address N*M-1 is issued.
- GAP:
  - Counts GAP cycles.
  - Then goes to WAIT if cont=1, else to IDLE.
- pix_valid is mem_en delayed one cycle. pix_data is mem_rdata registered with it. Markers are derived from the delayed row/col.
- pix_valid is high for exactly N*M consecutive cycles per frame, with no gaps. The downstream receiver resets its write index whenever valid drops, so any gap corrupts the frame.
- start is ignored outside IDLE.
- cont falling mid-frame: the current frame completes, then the FSM goes to IDLE.
- dn_busy is ignored once STREAM has begun.
- frame_cnt increments and done pulses in the same cycle.
- Reset (any time, including mid-frame) behaves identically:
  - FSM -> IDLE and all counters cleared.
  - All outputs 0: mem_en, mem_addr, pix_data, pix_valid, sof, eol, eof, busy, done, frame_cnt.
  - A partially sent frame is not resumed.

## Timing
- start high at edge T in IDLE, dn_busy low at T+1:
  - STREAM entered at T+2, with mem_en and mem_addr=0 in that cycle.
  - pix_valid and sof first high at T+3.
- Memory-to-output latency: 1 cycle from the mem_en cycle.
- For a frame whose first pixel is at cycle F:
  - Last pixel (eof) at F+N*M-1.
  - done pulse at F+N*M.
- Next frame's first pixel no earlier than F+N*M+GAP+2. This is reached in continuous mode with dn_busy low.
- Frame boundary markers:
  - For N*M=1, sof, eol and eof are all high together.
  - For M=1, eol is high on every pixel.

## Configuration
- PIXEL_FRAME_TX_TESTPAT_EN
  - Defined:
    - Adds input pat_sel (1 bit, sampled at STREAM entry and held for the frame).
    - pat_sel=1: pix_data = (row+col) mod 256, mem_en stays 0, and timing is identical to memory mode.
    - pat_sel=0: normal memory mode.
  - Undefined: no pat_sel port; pix_data always comes from memory.

## Structure
- Shared package pix_stream_pkg:
  - FSM state enum.
  - PIX_W=8.
  - Default N/M/GAP constants.
  - Function clog2 for ADDR_W checks.
- One sub-module, pix_tx_raster_cnt:
  - Linear address plus row/col counters with the last-col and last-pixel flags.
  - Reused later by the filter's output side.

## Test plan
All cases use N=4, M=3, GAP=2 and a RAM preloaded with mem[a]=a+16.
- Single shot: start with dn_busy=0 -> exactly 12 valid pixels 16..27 on consecutive cycles; sof on 16; eol on 18, 21, 24, 27; eof on 27; done one cycle later; frame_cnt=1; busy low after GAP.
- Backpressure at start: dn_busy held high 10 cycles after start -> no mem_en, busy=1; first pixel 2 cycles after dn_busy falls.
- Continuous mode: cont=1 for 3 frames -> three 12-pixel bursts separated by exactly GAP+2 idle cycles; frame_cnt=3.
- Mid-frame reset: rst at pixel 5 -> all outputs 0 immediately; new start gives a full frame beginning at 16.
- Ignored start: start pulsed during STREAM and during GAP (cont=0) -> exactly one frame emitted.
- With PIXEL_FRAME_TX_TESTPAT_EN and pat_sel=1 -> pixels 0,1,2,1,2,3,2,3,4,3,4,5; mem_en never high.
